ps2_key_tracker: RTL

Parametrised successor to the single-key PS/2 press processor. Consumes raw scan-code bytes from the PS/2 receiver through a valid/ready handshake and decodes the E0 extended prefix and the F0 break prefix. Tracks up to MAX_KEYS simultaneously held keys, suppresses or tags typematic repeats, and counts distinct presses. Pushes decoded key events into an output FIFO that feeds the ASCII converter and display logic.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_event_fifo.sv | 65 ++++++
 rtl/ps2_key_tracker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key tracker: scan-code byte constants,
// parser state encoding and the decoded key event record.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  // Field names avoid the SystemVerilog keywords 'release' and 'repeat'.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       is_release;
    logic       is_repeat;
  } key_event_t;

  // Keyboard status/handshake bytes that carry no key information.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO. The head entry is presented on dout
// whenever valid is high; pushes while full and pops while empty are ignored.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  key_event_t din,
  output logic       full,
  input  logic       pop,
  output logic       valid,
  output key_event_t dout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  key_event_t       mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Status flags and qualified push/pop derived from the occupancy counter.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    valid   = (count != {CNT_W{1'b0}});
    do_push = push && !full;
    do_pop  = pop && valid;
    dout    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents are don't-care until written, gated by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder: strips E0/F0 prefixes, tracks up to MAX_KEYS held
// keys, filters or tags typematic repeats and queues decoded key events.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int MAX_KEYS   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int COUNT_W    = 8,
  parameter int REPEAT_EN  = 0
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_release,
  output logic                          ev_repeat,
  output logic [$clog2(MAX_KEYS+1)-1:0] held_count,
  output logic [COUNT_W-1:0]            press_count,
  output logic [7:0]                    last_code,
  output logic                          overflow
);

  localparam int   HC_W     = $clog2(MAX_KEYS + 1);
  localparam int   IDX_W    = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;
  localparam logic EMIT_REP = (REPEAT_EN != 0);

  // Index of the lowest set bit; the held table never exceeds eight slots.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  ps2_state_t          state;
  ps2_state_t          state_next;
  logic                accept;
  logic                fifo_full;
  logic                is_make;
  logic                is_break;
  logic                ext_flag;

  logic [MAX_KEYS-1:0] slot_valid;
  logic [8:0]          slot_key [MAX_KEYS];
  logic [MAX_KEYS-1:0] match_vec;
  logic [MAX_KEYS-1:0] free_vec;
  logic                hit;
  logic                free_found;
  logic [IDX_W-1:0]    hit_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                new_make;

  logic                push;
  key_event_t          ev_in;
  key_event_t          ev_head;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && !fifo_full;

  // Parser state register; reset discards any partially received sequence.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prefix decoding: classify each accepted byte as prefix, make, break or noise.
  always_comb begin
    state_next = state;
    is_make    = 1'b0;
    is_break   = 1'b0;
    ext_flag   = 1'b0;
    if (accept) begin
      if (in_data == PS2_EXT) begin
        state_next = ST_EXT;
      end else if (in_data == PS2_BRK) begin
        state_next = (state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else begin
        case (state)
          ST_IDLE: begin
            if (is_ctrl_byte(in_data)) begin
              state_next = ST_IDLE;
            end else begin
              is_make = 1'b1;
            end
          end
          ST_EXT: begin
            is_make    = 1'b1;
            ext_flag   = 1'b1;
            state_next = ST_IDLE;
          end
          ST_BRK: begin
            is_break   = 1'b1;
            state_next = ST_IDLE;
          end
          ST_EXT_BRK: begin
            is_break   = 1'b1;
            ext_flag   = 1'b1;
            state_next = ST_IDLE;
          end
          default: begin
            state_next = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_next = state;
    end
  end

  // Held-table lookup: matching slot for this key and lowest free slot.
  always_comb begin
    for (int i = 0; i < MAX_KEYS; i++) begin
      match_vec[i] = slot_valid[i] && (slot_key[i] == {ext_flag, in_data});
      free_vec[i]  = !slot_valid[i];
    end
    hit        = |match_vec;
    free_found = |free_vec;
    hit_idx    = IDX_W'(lowest_set(8'(match_vec)));
    free_idx   = IDX_W'(lowest_set(8'(free_vec)));
    new_make   = accept && is_make && !hit;
  end

  // Event construction: repeats are only forwarded when tagging is enabled.
  always_comb begin
    ev_in.code       = in_data;
    ev_in.ext        = ext_flag;
    ev_in.is_release = is_break;
    ev_in.is_repeat  = is_make && hit;
    push             = accept && (is_break || (is_make && (!hit || EMIT_REP)));
  end

  // Held table occupancy, press statistics and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      slot_valid  <= {MAX_KEYS{1'b0}};
      held_count  <= {HC_W{1'b0}};
      press_count <= {COUNT_W{1'b0}};
      last_code   <= 8'h00;
      overflow    <= 1'b0;
    end else if (new_make) begin
      press_count <= press_count + COUNT_W'(1);
      last_code   <= in_data;
      if (free_found) begin
        slot_valid[free_idx] <= 1'b1;
        held_count           <= held_count + HC_W'(1);
      end else begin
        overflow <= 1'b1;
      end
    end else if (accept && is_break && hit) begin
      slot_valid[hit_idx] <= 1'b0;
      held_count          <= held_count - HC_W'(1);
    end
  end

  // Key storage for occupied slots; only meaningful where slot_valid is set.
  always_ff @(posedge clk) begin
    if (new_make && free_found) begin
      slot_key[free_idx] <= {ext_flag, in_data};
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .din   (ev_in),
    .full  (fifo_full),
    .pop   (ev_ready),
    .valid (ev_valid),
    .dout  (ev_head)
  );

  assign ev_code    = ev_head.code;
  assign ev_ext     = ev_head.ext;
  assign ev_release = ev_head.is_release;
  assign ev_repeat  = ev_head.is_repeat;

endmodule
